// File: rtl/pulpemu_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pulpemu_run_sequencer
// Brief    : Host-driven SoC run sequencer: reset/clock bring-up, run, stdout
//            flush handshake, completion capture and run-time watchdog.
// Revision : 1.0
// ============================================================================
module pulpemu_run_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int TMO_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [TMO_W-1:0] timeout_i,
    input  logic             eoc_i,
    input  logic [1:0]       return_val_i,
    input  logic             stdout_wait_i,
    input  logic             flush_ack_i,
    output logic             cg_clken_o,
    output logic             pulp_soc_rst_n_o,
    output logic             fetch_en_o,
    output logic             stdout_flushed_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [1:0]       result_o,
    output logic [2:0]       state_o
);

    localparam int RST_EFF    = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_MAX    = (RST_EFF > SETTLE_EFF) ? RST_EFF : SETTLE_EFF;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] C_RST_LOAD    = CNT_W'(RST_EFF - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_EFF - 1);

    localparam logic [2:0] C_IDLE       = 3'd0;
    localparam logic [2:0] C_HOLD_RST   = 3'd1;
    localparam logic [2:0] C_CLK_SETTLE = 3'd2;
    localparam logic [2:0] C_RELEASE    = 3'd3;
    localparam logic [2:0] C_RUN        = 3'd4;
    localparam logic [2:0] C_FLUSH      = 3'd5;
    localparam logic [2:0] C_DONE       = 3'd6;
    localparam logic [2:0] C_FAULT      = 3'd7;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TMO_W-1:0] r_run_cnt;
    logic             r_start_q;
    logic             r_armed;
    logic             r_flushed;
    logic [1:0]       r_result;
    logic             w_edge;
    logic             w_tmo_hit;

    // r_armed masks the first post-reset cycle so a start held through reset is not an edge
    assign w_edge    = start_i & ~r_start_q & r_armed;
    assign w_tmo_hit = (timeout_i != '0) &&
                       (({1'b0, r_run_cnt} + (TMO_W + 1)'(1)) == {1'b0, timeout_i});

    assign state_o          = r_state;
    assign result_o         = r_result;
    assign stdout_flushed_o = r_flushed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= C_IDLE;
            r_cnt     <= '0;
            r_run_cnt <= '0;
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
            r_flushed <= 1'b0;
            r_result  <= 2'b00;
        end else begin
            r_start_q <= start_i;
            r_armed   <= 1'b1;
            if (abort_i) begin
                r_state   <= C_IDLE;
                r_flushed <= 1'b0;
                r_result  <= 2'b00;
            end else begin
                case (r_state)
                    C_IDLE, C_DONE, C_FAULT: begin
                        if (w_edge) begin
                            r_state  <= C_HOLD_RST;
                            r_cnt    <= C_RST_LOAD;
                            r_result <= 2'b00;
                        end
                    end
                    C_HOLD_RST: begin
                        if (r_cnt == '0) begin
                            r_state <= C_CLK_SETTLE;
                            r_cnt   <= C_SETTLE_LOAD;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    C_CLK_SETTLE: begin
                        if (r_cnt == '0) begin
                            r_state <= C_RELEASE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    C_RELEASE: begin
                        r_state   <= C_RUN;
                        r_run_cnt <= '0;
                    end
                    C_RUN: begin
                        if (r_run_cnt != '1) begin
                            r_run_cnt <= r_run_cnt + TMO_W'(1);
                        end
                        if (eoc_i) begin
                            r_state  <= C_DONE;
                            r_result <= return_val_i;
                        end else if (w_tmo_hit) begin
                            r_state <= C_FAULT;
                        end else if (stdout_wait_i) begin
                            r_state <= C_FLUSH;
                        end
                    end
                    C_FLUSH: begin
                        // eoc is deliberately not sampled here; it is seen again back in RUN
                        if (!stdout_wait_i && r_flushed) begin
                            r_flushed <= 1'b0;
                            r_state   <= C_RUN;
                        end else if (flush_ack_i) begin
                            r_flushed <= 1'b1;
                        end
                    end
                    default: r_state <= C_IDLE;
                endcase
            end
        end
    end

    // Control/status outputs are registered decodes of the current state (one-cycle lag)
    always_ff @(posedge clk) begin
        if (rst) begin
            cg_clken_o       <= 1'b0;
            pulp_soc_rst_n_o <= 1'b0;
            fetch_en_o       <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            timeout_o        <= 1'b0;
        end else begin
            cg_clken_o       <= (r_state == C_CLK_SETTLE) || (r_state == C_RELEASE) ||
                                (r_state == C_RUN) || (r_state == C_FLUSH) ||
                                (r_state == C_DONE);
            pulp_soc_rst_n_o <= (r_state == C_RELEASE) || (r_state == C_RUN) ||
                                (r_state == C_FLUSH) || (r_state == C_DONE);
            fetch_en_o       <= (r_state == C_RUN) || (r_state == C_FLUSH);
            busy_o           <= (r_state == C_HOLD_RST) || (r_state == C_CLK_SETTLE) ||
                                (r_state == C_RELEASE) || (r_state == C_RUN) ||
                                (r_state == C_FLUSH);
            done_o           <= (r_state == C_DONE);
            timeout_o        <= (r_state == C_FAULT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulpemu_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulpemu_run_sequencer
// Brief    : Directed scenarios followed by random stimulus against a
//            phase-length reference model of the run sequencer.
// Revision : 1.0
// ============================================================================
module tb_pulpemu_run_sequencer;

    localparam int  RST_N    = 16;
    localparam int  SETTLE_N = 8;
    localparam longint RUN_MAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] timeout_i = '0;
    logic        eoc_i = 1'b0;
    logic [1:0]  return_val_i = 2'b00;
    logic        stdout_wait_i = 1'b0;
    logic        flush_ack_i = 1'b0;
    logic        cg_clken_o, pulp_soc_rst_n_o, fetch_en_o, stdout_flushed_o;
    logic        busy_o, done_o, timeout_o;
    logic [1:0]  result_o;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // reference model: phase position counted up in elapsed cycles
    int     m_st = 0;
    int     m_k = 0;
    longint m_run = 0;
    bit     m_startq = 0, m_armed = 0, m_fl = 0;
    bit     m_cg = 0, m_rn = 0, m_fe = 0, m_busy = 0, m_done = 0, m_tmo = 0;
    int     m_res = 0;

    pulpemu_run_sequencer dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .timeout_i(timeout_i), .eoc_i(eoc_i), .return_val_i(return_val_i),
        .stdout_wait_i(stdout_wait_i), .flush_ack_i(flush_ack_i),
        .cg_clken_o(cg_clken_o), .pulp_soc_rst_n_o(pulp_soc_rst_n_o),
        .fetch_en_o(fetch_en_o), .stdout_flushed_o(stdout_flushed_o),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .result_o(result_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int  old;
        bit  edge_seen;
        old = m_st;
        if (rst) begin
            m_st = 0; m_k = 0; m_run = 0; m_startq = 0; m_armed = 0; m_fl = 0; m_res = 0;
            m_cg = 0; m_rn = 0; m_fe = 0; m_busy = 0; m_done = 0; m_tmo = 0;
            return;
        end
        edge_seen = start_i && !m_startq && m_armed;
        m_startq  = start_i;
        m_armed   = 1;
        m_cg   = old inside {2, 3, 4, 5, 6};
        m_rn   = old inside {3, 4, 5, 6};
        m_fe   = old inside {4, 5};
        m_busy = old inside {1, 2, 3, 4, 5};
        m_done = (old == 6);
        m_tmo  = (old == 7);
        if (abort_i) begin
            m_st = 0; m_fl = 0; m_res = 0;
        end else if (old == 0 || old == 6 || old == 7) begin
            if (edge_seen) begin m_st = 1; m_k = 1; m_res = 0; end
        end else if (old == 1) begin
            if (m_k == RST_N) begin m_st = 2; m_k = 1; end else m_k++;
        end else if (old == 2) begin
            if (m_k == SETTLE_N) m_st = 3; else m_k++;
        end else if (old == 3) begin
            m_st = 4; m_run = 0;
        end else if (old == 4) begin
            if (eoc_i) begin m_st = 6; m_res = return_val_i; end
            else if (timeout_i != 0 && m_run + 1 == longint'(timeout_i)) m_st = 7;
            else if (stdout_wait_i) m_st = 5;
            if (m_run < RUN_MAX) m_run++;
        end else begin
            if (!stdout_wait_i && m_fl) begin m_fl = 0; m_st = 4; end
            else if (flush_ack_i) m_fl = 1;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (mon_en) begin
            chk("state", 32'(state_o), 32'(m_st));
            chk("ctrl", {29'd0, cg_clken_o, pulp_soc_rst_n_o, fetch_en_o}, {29'd0, m_cg, m_rn, m_fe});
            chk("status", {29'd0, busy_o, done_o, timeout_o}, {29'd0, m_busy, m_done, m_tmo});
            chk("result", 32'(result_o), 32'(m_res));
            chk("flushed", 32'(stdout_flushed_o), 32'(m_fl));
        end
    end

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_o !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", 32'(state_o), 32'(s));
    endtask

    function automatic logic [31:0] all_out();
        return {22'd0, cg_clken_o, pulp_soc_rst_n_o, fetch_en_o, stdout_flushed_o,
                busy_o, done_o, timeout_o, result_o, 1'b0};
    endfunction

    initial begin
        int n;
        start_i = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("reset_out", all_out(), 32'd0);
        chk("reset_state", 32'(state_o), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_run_held_start", 32'(state_o), 32'd0);
        start_i = 1'b0;
        @(negedge clk);

        // bring-up timing with defaults, edge in cycle 0
        start_i = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            if (c == 1 || c == 16) chk("hold_rst", 32'(state_o), 32'd1);
            if (c == 17 || c == 24) chk("clk_settle", 32'(state_o), 32'd2);
            if (c == 25) chk("release", 32'(state_o), 32'd3);
            if (c == 26) chk("run_entry", {28'd0, state_o, fetch_en_o}, {28'd0, 3'd4, 1'b0});
            if (c == 27) chk("fetch_en", 32'(fetch_en_o), 32'd1);
        end

        eoc_i = 1'b1; return_val_i = 2'b10; start_i = 1'b0;
        @(negedge clk);
        eoc_i = 1'b0;
        chk("done_state", {27'd0, state_o, result_o}, {27'd0, 3'd6, 2'd2});
        @(negedge clk);
        chk("done_out", {30'd0, done_o, fetch_en_o}, {30'd0, 1'b1, 1'b0});
        start_i = 1'b1;
        @(negedge clk);
        chk("restart", {27'd0, state_o, result_o}, {27'd0, 3'd1, 2'd0});

        // watchdog: exactly 5 RUN cycles
        timeout_i = 32'd5;
        wait_state(3'd4, 40);
        n = 0;
        while (state_o == 3'd4 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_len", 32'(n), 32'd5);
        chk("fault_state", 32'(state_o), 32'd7);
        @(negedge clk);
        chk("fault_out", {28'd0, timeout_o, cg_clken_o, pulp_soc_rst_n_o, fetch_en_o}, 32'b1000);

        // abort in CLK_SETTLE
        start_i = 1'b0; @(negedge clk); start_i = 1'b1;
        wait_state(3'd2, 40);
        abort_i = 1'b1; @(negedge clk); abort_i = 1'b0;
        chk("abort_settle", 32'(state_o), 32'd0);
        @(negedge clk); @(negedge clk);
        chk("abort_out", all_out(), 32'd0);
        // abort coincident with start edge in IDLE
        start_i = 1'b0; @(negedge clk);
        start_i = 1'b1; abort_i = 1'b1; @(negedge clk); abort_i = 1'b0;
        chk("abort_edge", 32'(state_o), 32'd0);
        @(negedge clk);
        chk("abort_edge_out", all_out(), 32'd0);

        // stdout flush handshake
        timeout_i = 32'd0;
        start_i = 1'b0; @(negedge clk); start_i = 1'b1;
        wait_state(3'd4, 40);
        stdout_wait_i = 1'b1;
        repeat (3) @(negedge clk);
        flush_ack_i = 1'b1; @(negedge clk); flush_ack_i = 1'b0;
        @(negedge clk);
        chk("flush", {28'd0, state_o, stdout_flushed_o}, {28'd0, 3'd5, 1'b1});
        repeat (2) @(negedge clk);
        chk("flush_hold", 32'(stdout_flushed_o), 32'd1);
        stdout_wait_i = 1'b0;
        @(negedge clk);
        chk("flush_exit", {28'd0, state_o, stdout_flushed_o}, {28'd0, 3'd4, 1'b0});

        // reset mid-run with start held
        rst = 1'b1; @(negedge clk);
        chk("rst_run", {28'd0, state_o, fetch_en_o}, 32'd0);
        chk("rst_ctrl", {30'd0, cg_clken_o, pulp_soc_rst_n_o}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_no_rerun", 32'(state_o), 32'd0);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) start_i = ~start_i;
            abort_i = ($urandom_range(0, 79) == 0);
            eoc_i   = ($urandom_range(0, 24) == 0);
            return_val_i = 2'($urandom_range(0, 3));
            if (stdout_wait_i) stdout_wait_i = ($urandom_range(0, 5) != 0);
            else stdout_wait_i = ($urandom_range(0, 14) == 0);
            flush_ack_i = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0)
                timeout_i = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
